// File: rtl/sevseg_scan_bin.sv
// Multiplexed seven-segment driver: a loaded binary value is converted to BCD by a
// serial shift-add-3 engine, then scanned onto shared active-low segment/anode lines.
module sevseg_scan_bin #(
    parameter int NUM_DIGITS   = 4,
    parameter int BIN_W        = 14,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  lz_blank,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit
);

    // Accumulator holds every decimal digit of 2^BIN_W-1 (floor(BIN_W*log10 2)+1).
    localparam int ACC_RAW    = (BIN_W * 301) / 1000 + 1;
    localparam int ACC_DIGITS = (ACC_RAW > NUM_DIGITS) ? ACC_RAW : NUM_DIGITS;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int DISP_W     = 4 * NUM_DIGITS;
    localparam int CNT_W      = $clog2(BIN_W);
    localparam int REF_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] OVF_LIMIT = pow10(NUM_DIGITS);

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [BIN_W-1:0]      shift_q, shift_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  ovf_pend_q, ovf_pend_d;
    logic                  ovf_q, ovf_d;
    logic [DISP_W-1:0]     disp_q, disp_d;
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [FRM_W-1:0]      frm_q, frm_d;
    logic                  blink_q, blink_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] digit_q, digit_d;

    // ---------------- conversion step ----------------
    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_step;
    logic [BIN_W-1:0] shift_step;

    genvar gi;
    generate
        for (gi = 0; gi < ACC_DIGITS; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                        acc_q[gi*4 +: 4] + 4'd3 : acc_q[gi*4 +: 4];
        end
    endgenerate

    assign acc_step   = {acc_adj[ACC_W-2:0], shift_q[BIN_W-1]};
    assign shift_step = {shift_q[BIN_W-2:0], 1'b0};

    always_comb begin
        shift_d    = shift_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        disp_d     = disp_q;
        if (busy_q) begin
            shift_d = shift_step;
            acc_d   = acc_step;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                busy_d = 1'b0;
                disp_d = acc_step[DISP_W-1:0];
                ovf_d  = ovf_pend_q;
            end
        end else if (load) begin
            shift_d    = bin_in;
            acc_d      = '0;
            cnt_d      = '0;
            busy_d     = 1'b1;
            ovf_pend_d = (64'(bin_in) >= OVF_LIMIT);
        end
    end

    // ---------------- scan timing ----------------
    logic ref_wrap;
    logic idx_last;

    always_comb begin
        ref_wrap = (ref_q == REF_W'(REFRESH_DIV - 1));
        idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));
        ref_d    = ref_wrap ? '0 : ref_q + 1'b1;
        idx_d    = idx_q;
        frm_d    = frm_q;
        blink_d  = blink_q;
        if (ref_wrap) begin
            idx_d = idx_last ? '0 : idx_q + 1'b1;
            if (idx_last) begin
                if (frm_q == FRM_W'(BLINK_FRAMES - 1)) begin
                    frm_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end
        end
    end

    // ---------------- segment/anode generation ----------------
    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] zero_from;

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = disp_q[gi*4 +: 4];
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign zero_from[gi] = (nib[gi] == 4'd0);
            end else begin : g_mid
                assign zero_from[gi] = (nib[gi] == 4'd0) && zero_from[gi+1];
            end
        end
    endgenerate

    logic blank_now;

    // seg and digit come from the same idx_q, so they always switch together.
    always_comb begin
        blank_now = (blink_q && blink_mask[idx_q]) ||
                    (!ovf_q && lz_blank && (idx_q != '0) && zero_from[idx_q]);
        if (blank_now) begin
            seg_d = SEG_BLANK;
        end else if (ovf_q) begin
            seg_d = SEG_DASH;
        end else begin
            seg_d = decode(nib[idx_q]);
        end
        digit_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            ref_q      <= '0;
            idx_q      <= '0;
            frm_q      <= '0;
            blink_q    <= 1'b0;
            seg_q      <= SEG_BLANK;
            digit_q    <= '1;
        end else begin
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            frm_q      <= frm_d;
            blink_q    <= blink_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
        end
    end

    assign busy     = busy_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign digit    = digit_q;

endmodule
